// File: rtl/seq_restoring_divider_if.sv
// Handshake and data bundle for seq_restoring_divider.
// The controller side drives start and operands; the divider side returns
// status and results.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider for unsigned WIDTH-bit operands.
// One quotient bit is produced per clock by a shift/compare/subtract step.
// A zero divisor skips the iterations and reports all-ones quotient,
// the dividend as remainder, and raises div_by_zero.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_restoring_divider_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] div_q,   div_d;     // captured divisor D
  logic [WIDTH-1:0] qsh_q,   qsh_d;     // dividend/quotient shift register Q
  logic [WIDTH:0]   rem_q,   rem_d;     // partial remainder R, one guard bit
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             dbz_q,   dbz_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Shifted partial remainder and its trial subtraction for this iteration.
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] qsh_next_s;
  logic [WIDTH:0]   rem_next_s;

  // Datapath for one restoring step: shift in next dividend bit, compare, subtract.
  always_comb begin
    shift_s    = {rem_q[WIDTH-1:0], qsh_q[WIDTH-1]};
    diff_s     = shift_s - {1'b0, div_q};
    ge_s       = (shift_s >= {1'b0, div_q});
    qsh_next_s = {qsh_q[WIDTH-2:0], ge_s};
    if (ge_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = shift_s;
    end
  end

  // Next-state and result logic; every register holds unless updated below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    qsh_d   = qsh_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          div_d = bus.divisor;
          qsh_d = bus.dividend;
          rem_d = {(WIDTH + 1){1'b0}};
          cnt_d = {CW{1'b0}};
          dbz_d = 1'b0;
          if (bus.divisor == {WIDTH{1'b0}}) begin
            state_d = S_DONE;
            quot_d  = {WIDTH{1'b1}};
            res_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        qsh_d = qsh_next_s;
        rem_d = rem_next_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          quot_d  = qsh_next_s;
          res_d   = rem_next_s[WIDTH-1:0];
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and result registers with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      div_q   <= {WIDTH{1'b0}};
      qsh_q   <= {WIDTH{1'b0}};
      rem_q   <= {(WIDTH + 1){1'b0}};
      quot_q  <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      qsh_q   <= qsh_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = res_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider at WIDTH=8 and WIDTH=16.
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_restoring_divider_if #(.WIDTH(8))  b8 ();
  seq_restoring_divider_if #(.WIDTH(16)) b16 ();

  seq_restoring_divider #(.WIDTH(8))  u_div8  (.clk(clk), .rst(rst), .bus(b8.slave));
  seq_restoring_divider #(.WIDTH(16)) u_div16 (.clk(clk), .rst(rst), .bus(b16.slave));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_q(input bit sel);
    return sel ? 32'(b16.quotient) : 32'(b8.quotient);
  endfunction
  function automatic logic [31:0] get_r(input bit sel);
    return sel ? 32'(b16.remainder) : 32'(b8.remainder);
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? b16.busy : b8.busy;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? b16.done : b8.done;
  endfunction
  function automatic logic get_z(input bit sel);
    return sel ? b16.div_by_zero : b8.div_by_zero;
  endfunction

  task automatic drive(input bit sel, input logic st, input int a, input int b);
    if (sel) begin
      b16.start = st; b16.dividend = 16'(a); b16.divisor = 16'(b);
    end else begin
      b8.start = st;  b8.dividend = 8'(a);   b8.divisor = 8'(b);
    end
  endtask

  task automatic check_outputs_zero(input string tag, input bit sel);
    check({tag, ".busy"}, 32'(get_busy(sel)), 32'd0);
    check({tag, ".done"}, 32'(get_done(sel)), 32'd0);
    check({tag, ".q"},    get_q(sel),         32'd0);
    check({tag, ".r"},    get_r(sel),         32'd0);
    check({tag, ".dbz"},  32'(get_z(sel)),    32'd0);
  endtask

  // Called at a negedge. Issues a/b, follows the run until done (bounded),
  // and returns at the negedge inside the done cycle with start low.
  // edges counts clock edges after the accepting edge before done is seen;
  // a one-cycle start poke with 50/5 is issued when edges == poke.
  task automatic run(input string tag, input bit sel, input int a, input int b,
                     input int exp_q, input int exp_r, input bit exp_z,
                     input int poke = -1);
    int w;
    int edges;
    int busy_cycles;
    w = sel ? 16 : 8;
    edges = 0;
    busy_cycles = 0;
    drive(sel, 1'b1, a, b);
    @(negedge clk);
    drive(sel, 1'b0, a, b);
    while (!get_done(sel) && edges < 40) begin
      if (get_busy(sel)) busy_cycles++;
      if (edges == poke) drive(sel, 1'b1, 50, 5);
      else drive(sel, 1'b0, a, b);
      @(negedge clk);
      edges++;
    end
    drive(sel, 1'b0, a, b);
    check({tag, ".latency"}, 32'(edges), exp_z ? 32'd0 : 32'(w));
    check({tag, ".busy_cycles"}, 32'(busy_cycles), exp_z ? 32'd0 : 32'(w));
    check({tag, ".busy_at_done"}, 32'(get_busy(sel)), 32'd0);
    check({tag, ".q"}, get_q(sel), 32'(exp_q));
    check({tag, ".r"}, get_r(sel), 32'(exp_r));
    check({tag, ".dbz"}, 32'(get_z(sel)), 32'(exp_z));
  endtask

  initial begin
    int a;
    int b;
    int done_seen;
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);

    // Reset state for both widths.
    repeat (2) @(negedge clk);
    check_outputs_zero("reset8", 1'b0);
    check_outputs_zero("reset16", 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Basic and boundary operands, WIDTH=8.
    run("d200_7", 1'b0, 200, 7, 28, 4, 1'b0);
    @(negedge clk);
    check("done_pulse_width", 32'(get_done(1'b0)), 32'd0);
    check("result_held", get_q(1'b0), 32'd28);
    run("d5_9",     1'b0, 5,   9,   0,   5, 1'b0);
    run("d255_1",   1'b0, 255, 1,   255, 0, 1'b0);
    run("d255_255", 1'b0, 255, 255, 1,   0, 1'b0);
    run("d0_13",    1'b0, 0,   13,  0,   0, 1'b0);
    @(negedge clk);

    // Divide by zero, then a normal division clears the flag.
    run("d100_0", 1'b0, 100, 0, 255, 100, 1'b1);
    @(negedge clk);
    check("dbz_done_falls", 32'(get_done(1'b0)), 32'd0);
    check("dbz_held", 32'(get_z(1'b0)), 32'd1);
    run("d9_3", 1'b0, 9, 3, 3, 0, 1'b0);
    @(negedge clk);

    // Start pulsed mid-run is ignored; start in the done cycle is accepted.
    run("ignored_start", 1'b0, 200, 7, 28, 4, 1'b0, 3);
    run("back_to_back", 1'b0, 50, 5, 10, 0, 1'b0);
    run("b2b_zero", 1'b0, 77, 0, 255, 77, 1'b1);
    run("b2b_after_zero", 1'b0, 77, 8, 9, 5, 1'b0);
    @(negedge clk);

    // Reset during the fourth iteration abandons the division.
    drive(1'b0, 1'b1, 200, 7);
    @(negedge clk);
    drive(1'b0, 1'b0, 200, 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("mid_reset", 1'b0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (get_done(1'b0) || get_busy(1'b0)) done_seen++;
    end
    check("mid_reset.no_activity", 32'(done_seen), 32'd0);
    run("d17_4", 1'b0, 17, 4, 4, 1, 1'b0);
    @(negedge clk);

    // Reset wins over start on the same edge.
    rst = 1'b1;
    drive(1'b0, 1'b1, 200, 7);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 200, 7);
    check_outputs_zero("rst_over_start", 1'b0);
    @(negedge clk);
    check("rst_over_start.idle", 32'(get_busy(1'b0)), 32'd0);

    // Wider instance.
    run("w16_65535_3", 1'b1, 65535, 3, 21845, 0, 1'b0);
    run("w16_1000_0", 1'b1, 1000, 0, 65535, 1000, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(1, 65535));
      run("w16_rand", 1'b1, a, b, a / b, a % b, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Parametrised sequential restoring divider for unsigned WIDTH-bit operands. It computes one quotient bit per clock using a shift/compare/subtract datapath; the compare is an internal `R >= D` update decision. It uses a start/busy/done handshake so a controller can issue divisions back-to-back. It replaces the fixed 8-bit, externally sequenced compare stage with a self-contained, width-generic unit that also flags divide-by-zero.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits. Must be at least 2.
- `clk`  input  1: clock. All state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request a division. Sampled only when `busy`=0.
- `dividend`  input  WIDTH: unsigned dividend. Captured on the accepting edge.
- `divisor`  input  WIDTH: unsigned divisor. Captured on the accepting edge.
- `busy`  output  1: high while iterations are in progress (state RUN).
- `done`  output  1: single-cycle pulse marking that `quotient`, `remainder` and `div_by_zero` are valid.
- `quotient`  output  WIDTH: result quotient. Held until the next accepted start.
- `remainder`  output  WIDTH: result remainder. Held until the next accepted start.
- `div_by_zero`  output  1: set with `done` when the captured divisor was 0. Held until the next accepted start.

## Operation
- **States:** IDLE, RUN, DONE. The iteration counter is ceil(log2(WIDTH+1)) bits wide.
- **Accept:** the `start`=1 sample is taken in IDLE or DONE (`busy`=0).
  - Divisor register D <= `divisor`.
  - Quotient register Q <= `dividend`.
  - Partial remainder R (WIDTH+1 bits) <= 0.
  - Counter <= 0.
  - `div_by_zero` <= 0.
- **Zero divisor:** if `divisor`==0 on accept, go directly to DONE.
  - `quotient` = all ones, `remainder` = `dividend`, `div_by_zero` = 1.
  - No RUN cycles; `busy` never rises.
- **Non-zero divisor:** go to RUN.
- **RUN iteration (one per edge):**
  - Form S = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If S >= {1'b0, D}: R <= S − D and Q <= {Q[WIDTH-2:0], 1}.
  - Otherwise: R <= S and Q <= {Q[WIDTH-2:0], 0}.
  - Counter increments each iteration.
- **Width rule:** R is WIDTH+1 bits, so S ≤ 2D−1 never overflows. The final R is always < D, and its upper bit is 0.
- **End of RUN:** after the WIDTH-th iteration, go to DONE.
  - `quotient` <= final Q, `remainder` <= final R[WIDTH-1:0].
- **DONE:** lasts exactly one cycle.
  - Next state is IDLE, or RUN/DONE if a new `start` is accepted in that cycle.
- **Ignored start:** `start` while `busy`=1 has no effect. Operand changes during RUN have no effect.
- **Reset:** `rst`=1 at any edge, including mid-RUN, forces IDLE.
  - Counter = 0; D, Q, R = 0.
  - Outputs after reset: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - An in-flight division is abandoned with no `done`.
  - `rst` has priority over `start` on the same edge.

## Timing
- **Edge E (accepts start), non-zero divisor:**
  - `busy`=1 from after E through the edge E+WIDTH.
  - Iterations occur on edges E+1 … E+WIDTH.
  - After edge E+WIDTH: `busy`=0, `done`=1, results valid.
  - Latency is WIDTH cycles from the accepting edge to `done`.
- **Zero divisor:** `done`=1 and `div_by_zero`=1 in the cycle after E (latency 1).
- `done` falls after edge E+WIDTH+1 unless a zero-divisor start is accepted at that edge.
- **Back-to-back:** `start` held high during the `done` cycle is accepted. Throughput is one division per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Basic division:** WIDTH=8, `start` with 200/7 → `busy` for 8 cycles, `done` pulse 8 cycles after the accepting edge, `quotient`=28, `remainder`=4, `div_by_zero`=0.
- **Boundary operands (WIDTH=8):**
  - 5/9 → q=0, r=5.
  - 255/1 → q=255, r=0.
  - 255/255 → q=1, r=0.
  - 0/13 → q=0, r=0.
- **Divide by zero:** 100/0 → `done` and `div_by_zero` high one cycle after accept, `busy` never high, q=255, r=100. A following 9/3 clears the flag and gives q=3, r=0.
- **Start during busy:** `start` pulsed with 50/5 at cycle 3 of a 200/7 run → ignored, and the result is still 28 r 4. `start` held through the `done` cycle with 50/5 → accepted immediately, giving q=10, r=0 eight cycles later.
- **Reset mid-operation:** `rst` asserted at iteration 4 → next cycle all outputs are 0 and the state is IDLE, with no `done` pulse. A subsequent 17/4 gives q=4, r=1.
- **Wider instance:** WIDTH=16 with 65535/3 → q=21845, r=0 after 16 cycles. Also run 1000 random non-zero pairs checked against `/` and `%`.
